// File: rtl/m_lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit:
// access encodings, exception codes, address map and pipeline-register layout.
package m_lsu_pkg;

  typedef enum logic [2:0] {
    MT_W  = 3'd0,
    MT_HS = 3'd1,
    MT_HU = 3'd2,
    MT_BS = 3'd3,
    MT_BU = 3'd4
  } mem_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } lsu_state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_END       = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE     = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE     = 32'h0000_7F10;
  localparam logic [31:0] IG_BASE      = 32'h0000_7F20;
  localparam logic [31:0] TC_SIZE      = 32'd12;
  localparam logic [31:0] IG_SIZE      = 32'd4;
  localparam logic [31:0] TC_COUNT_OFF = 32'd8;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        is_ld;
    logic        is_st;
    logic [2:0]  mem_type;
    logic        ld_ov;
    logic        st_ov;
    logic [4:0]  exc;
  } em_reg_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    return (a >= base) && ((a - base) < size);
  endfunction

endpackage

// File: rtl/m_lsu_ldext.sv
// Load-data lane select and sign/zero extension for the memory stage.
module m_ldext
  import m_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  mem_type_i,
  output logic [31:0] data_o
);

  logic [15:0] half_s;
  logic [7:0]  byte_s;

  // pick the addressed lane, then extend according to access type
  always_comb begin
    half_s = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (lane_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    case (mem_type_i)
      MT_W:    data_o = rdata_i;
      MT_HS:   data_o = {{16{half_s[15]}}, half_s};
      MT_HU:   data_o = {16'h0000, half_s};
      MT_BS:   data_o = {{24{byte_s[7]}}, byte_s};
      default: data_o = {24'h00_0000, byte_s};
    endcase
  end

endmodule

// File: rtl/m_lsu.sv
// Memory-stage load/store unit: E/M register, address checks, req/gnt bus
// sequencing with wait/drain states, and load-data extension for writeback.
module m_lsu
  import m_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic [31:0] E_addr,
  input  logic [31:0] E_wdata,
  input  logic        E_isLd,
  input  logic        E_isSt,
  input  logic [2:0]  E_memType,
  input  logic        E_ExcLdOv,
  input  logic        E_ExcStOv,
  input  logic [4:0]  E_excCode,
  input  logic        flush,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_byteen,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic [31:0] m_rdata,
  output logic        M_stall,
  output logic [31:0] M_ldData,
  output logic        M_ldValid,
  output logic [4:0]  M_excCode
);

  em_reg_t    m_q, m_d;
  lsu_state_e state_q, state_d;
  bus_req_t   shadow_q, shadow_d, cur_s, bus_s;
  logic [31:0] ld_q, ld_d, ext_s;
  logic [4:0]  exc_s;
  logic        acc_s, misal_s, in_tc_s, in_range_s, tc_cnt_s, bad_s, issue_s, ld_done_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s;

  // address legality with carried/overflow/alignment/range/timer priority
  always_comb begin
    acc_s      = m_q.is_ld | m_q.is_st;
    in_tc_s    = in_window(m_q.addr, TC0_BASE, TC_SIZE) | in_window(m_q.addr, TC1_BASE, TC_SIZE);
    in_range_s = (m_q.addr <= DM_END) | in_tc_s | in_window(m_q.addr, IG_BASE, IG_SIZE);
    tc_cnt_s   = (m_q.addr == (TC0_BASE + TC_COUNT_OFF)) | (m_q.addr == (TC1_BASE + TC_COUNT_OFF));
    case (m_q.mem_type)
      MT_W:         misal_s = (m_q.addr[1:0] != 2'b00);
      MT_HS, MT_HU: misal_s = m_q.addr[0];
      default:      misal_s = 1'b0;
    endcase
    bad_s = misal_s | ~in_range_s | (in_tc_s & (m_q.mem_type != MT_W)) | (m_q.is_st & tc_cnt_s);
    if (m_q.exc != EXC_NONE) begin
      exc_s = m_q.exc;
    end else if (m_q.ld_ov) begin
      exc_s = EXC_ADEL;
    end else if (m_q.st_ov) begin
      exc_s = EXC_ADES;
    end else if (acc_s && bad_s) begin
      exc_s = m_q.is_ld ? EXC_ADEL : EXC_ADES;
    end else begin
      exc_s = EXC_NONE;
    end
  end

  assign issue_s = m_q.valid & acc_s & (exc_s == EXC_NONE) & ~flush;

  // byte enables and lane-replicated store data from the M register
  always_comb begin
    case (m_q.mem_type)
      MT_W: begin
        be_s = 4'b1111;
        wd_s = m_q.wdata;
      end
      MT_HS, MT_HU: begin
        be_s = 4'b0011 << m_q.addr[1:0];
        wd_s = {2{m_q.wdata[15:0]}};
      end
      default: begin
        be_s = 4'b0001 << m_q.addr[1:0];
        wd_s = {4{m_q.wdata[7:0]}};
      end
    endcase
    cur_s.we     = m_q.is_st;
    cur_s.addr   = {m_q.addr[31:2], 2'b00};
    cur_s.wdata  = wd_s;
    if (m_q.is_st) begin
      cur_s.byteen = be_s;
    end else begin
      cur_s.byteen = 4'b0000;
    end
  end

  // bus FSM: next state, request and stall
  always_comb begin
    state_d = state_q;
    m_req   = 1'b0;
    M_stall = 1'b0;
    bus_s   = cur_s;
    case (state_q)
      ST_IDLE: begin
        m_req = issue_s;
        if (issue_s && !m_gnt) begin
          state_d = ST_WAIT;
          M_stall = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        m_req   = 1'b1;
        M_stall = ~m_gnt;
        if (m_gnt) begin
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        m_req   = 1'b1;
        M_stall = 1'b1;
        bus_s   = shadow_q;
        if (m_gnt) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // E/M capture; a flush while waiting turns the slot into a bubble despite the stall
  always_comb begin
    m_d = m_q;
    if (!M_stall) begin
      if (flush) begin
        m_d = '0;
      end else begin
        m_d.valid    = E_valid;
        m_d.addr     = E_addr;
        m_d.wdata    = E_wdata;
        m_d.is_ld    = E_isLd;
        m_d.is_st    = E_isSt;
        m_d.mem_type = E_memType;
        m_d.ld_ov    = E_ExcLdOv;
        m_d.st_ov    = E_ExcStOv;
        m_d.exc      = E_excCode;
      end
    end else if ((state_q == ST_WAIT) && flush && !m_gnt) begin
      m_d = '0;
    end else begin
      m_d = m_q;
    end
  end

  // shadow tracks the live request so DRAIN can replay it after the slot is squashed
  always_comb begin
    if (state_q == ST_DRAIN) begin
      shadow_d = shadow_q;
    end else begin
      shadow_d = cur_s;
    end
    ld_d = ld_done_s ? ext_s : ld_q;
  end

  assign ld_done_s = m_gnt & m_req & (state_q != ST_DRAIN) & m_q.is_ld & ~flush;

  m_ldext u_ldext (
    .rdata_i    (m_rdata),
    .lane_i     (m_q.addr[1:0]),
    .mem_type_i (m_q.mem_type),
    .data_o     (ext_s)
  );

  // state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q      <= '0;
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      ld_q     <= 32'h0000_0000;
    end else begin
      m_q      <= m_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ld_q     <= ld_d;
    end
  end

  assign m_we      = bus_s.we;
  assign m_addr    = bus_s.addr;
  assign m_byteen  = bus_s.byteen;
  assign m_wdata   = bus_s.wdata;
  assign M_ldValid = ld_done_s;
  assign M_ldData  = ld_done_s ? ext_s : ld_q;
  assign M_excCode = m_q.valid ? exc_s : EXC_NONE;

endmodule

// File: tb/tb_m_lsu.sv
// Scoreboard bench for m_lsu: stimulus queues expected bus/exception responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_m_lsu;
  import m_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        E_valid = 1'b0, E_isLd = 1'b0, E_isSt = 1'b0;
  logic [31:0] E_addr = 32'd0, E_wdata = 32'd0;
  logic [2:0]  E_memType = 3'd0;
  logic        E_ExcLdOv = 1'b0, E_ExcStOv = 1'b0;
  logic [4:0]  E_excCode = 5'd0;
  logic        flush = 1'b0;
  logic        m_req, m_we, m_gnt = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata = 32'd0;
  logic [3:0]  m_byteen;
  logic        M_stall, M_ldValid;
  logic [31:0] M_ldData;
  logic [4:0]  M_excCode;

  m_lsu dut (
    .clk(clk), .reset(reset), .E_valid(E_valid), .E_addr(E_addr), .E_wdata(E_wdata),
    .E_isLd(E_isLd), .E_isSt(E_isSt), .E_memType(E_memType), .E_ExcLdOv(E_ExcLdOv),
    .E_ExcStOv(E_ExcStOv), .E_excCode(E_excCode), .flush(flush), .m_req(m_req),
    .m_we(m_we), .m_addr(m_addr), .m_byteen(m_byteen), .m_wdata(m_wdata), .m_gnt(m_gnt),
    .m_rdata(m_rdata), .M_stall(M_stall), .M_ldData(M_ldData), .M_ldValid(M_ldValid),
    .M_excCode(M_excCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        is_ld;
    logic [31:0] ld;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [4:0] exc_q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input logic is_ld, input logic [31:0] ld);
    bus_exp_t e;
    e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.is_ld = is_ld; e.ld = ld;
    bus_q.push_back(e);
  endtask

  // monitor: every completed bus beat and every raised exception is scored
  always @(negedge clk) begin
    if (reset) begin
      if (m_req && m_gnt) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_req", {31'd0, m_req}, 32'd0);
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          chk("bus_addr", m_addr, e.addr);
          chk("bus_we", {31'd0, m_we}, {31'd0, e.we});
          chk("bus_byteen", {28'd0, m_byteen}, {28'd0, e.be});
          if (e.we) chk("bus_wdata", m_wdata, e.wdata);
          chk("ld_valid", {31'd0, M_ldValid}, {31'd0, e.is_ld});
          if (e.is_ld) chk("ld_data", M_ldData, e.ld);
        end
      end
      if (M_excCode != 5'd0) begin
        if (exc_q.size() == 0) chk("unexpected_exc", {27'd0, M_excCode}, 32'd0);
        else chk("exc_code", {27'd0, M_excCode}, {27'd0, exc_q.pop_front()});
      end
    end
  end

  task automatic drive_e(input logic v, input logic ld, input logic st, input logic [2:0] mt,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic lov, input logic sov, input logic [4:0] ec);
    E_valid = v; E_isLd = ld; E_isSt = st; E_memType = mt; E_addr = a; E_wdata = wd;
    E_ExcLdOv = lov; E_ExcStOv = sov; E_excCode = ec;
  endtask

  // one instruction through M; gnt arrives after wt cycles of request
  task automatic do_op(input string nm, input logic ld, input logic st, input logic [2:0] mt,
                       input logic [31:0] a, input logic [31:0] wd, input logic lov,
                       input logic [4:0] ec, input int wt, input logic [31:0] rd,
                       input int exp_stall);
    int stalls = 0;
    @(posedge clk); #1;
    drive_e(1'b1, ld, st, mt, a, wd, lov, 1'b0, ec);
    @(posedge clk); #1;
    drive_e(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    m_rdata = rd;
    for (int k = 0; k <= wt; k++) begin
      m_gnt = (k == wt);
      @(negedge clk);
      if (M_stall) stalls++;
      @(posedge clk); #1;
    end
    m_gnt = 1'b0;
    chk({nm, "_stall_cycles"}, stalls, exp_stall);
    @(negedge clk);
    chk({nm, "_req_after"}, {31'd0, m_req}, 32'd0);
  endtask

  // store held in WAIT, flushed in cycle 2; gnt in cycle 4 or reset in DRAIN
  task automatic flush_run(input logic do_reset);
    @(posedge clk); #1;
    drive_e(1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_0020, 32'h5555_AAAA, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    drive_e(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    chk("fl_c1_stall", {31'd0, M_stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_c2_exc", {27'd0, M_excCode}, 32'd0);
    chk("fl_c2_req", {31'd0, m_req}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    if (do_reset) begin
      reset = 1'b0;
      #1;
      chk("rst_drain_req", {31'd0, m_req}, 32'd0);
      chk("rst_drain_stall", {31'd0, M_stall}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
    end else begin
      @(negedge clk);
      chk("fl_c3_addr", m_addr, 32'h0000_0020);
      chk("fl_c3_wdata", m_wdata, 32'h5555_AAAA);
      chk("fl_c3_stall", {31'd0, M_stall}, 32'd1);
      chk("fl_c3_exc", {27'd0, M_excCode}, 32'd0);
      @(posedge clk); #1;
      push_bus(32'h0000_0020, 1'b1, 4'b1111, 32'h5555_AAAA, 1'b0, 32'd0);
      m_gnt = 1'b1;
      @(negedge clk);
      chk("fl_c4_stall", {31'd0, M_stall}, 32'd1);
      @(posedge clk); #1;
      m_gnt = 1'b0;
      @(negedge clk);
      chk("fl_idle_req", {31'd0, m_req}, 32'd0);
      chk("fl_idle_stall", {31'd0, M_stall}, 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {20'd0, m_req, m_we, M_stall, M_ldValid, m_byteen, M_excCode, 1'b0}, 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_wdata", m_wdata, 32'd0);
    chk("rst_lddata", M_ldData, 32'd0);
    reset = 1'b1;

    push_bus(32'h0000_0010, 1'b0, 4'b0000, 32'd0, 1'b1, 32'hDEAD_BEEF);
    do_op("lw", 1'b1, 1'b0, MT_W, 32'h0000_0010, 32'd0, 1'b0, 5'd0, 0, 32'hDEAD_BEEF, 0);
    push_bus(32'h0000_0010, 1'b0, 4'b0000, 32'd0, 1'b1, 32'hFFFF_FF80);
    do_op("lb", 1'b1, 1'b0, MT_BS, 32'h0000_0013, 32'd0, 1'b0, 5'd0, 3, 32'h80FF_0000, 3);
    push_bus(32'h0000_0010, 1'b0, 4'b0000, 32'd0, 1'b1, 32'h0000_0080);
    do_op("lbu", 1'b1, 1'b0, MT_BU, 32'h0000_0013, 32'd0, 1'b0, 5'd0, 1, 32'h80FF_0000, 1);
    push_bus(32'h0000_0004, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'd0);
    do_op("sh", 1'b0, 1'b1, MT_HS, 32'h0000_0006, 32'h1234_ABCD, 1'b0, 5'd0, 0, 32'd0, 0);
    push_bus(32'h0000_0000, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'd0);
    do_op("sb", 1'b0, 1'b1, MT_BS, 32'h0000_0001, 32'h0000_00A5, 1'b0, 5'd0, 0, 32'd0, 0);
    push_bus(32'h0000_2FFC, 1'b0, 4'b0000, 32'd0, 1'b1, 32'hFFFF_8001);
    do_op("lh_dmend", 1'b1, 1'b0, MT_HS, 32'h0000_2FFE, 32'd0, 1'b0, 5'd0, 2, 32'h8001_0000, 2);
    push_bus(32'h0000_7F00, 1'b1, 4'b1111, 32'h1122_3344, 1'b0, 32'd0);
    do_op("sw_tc0", 1'b0, 1'b1, MT_W, 32'h0000_7F00, 32'h1122_3344, 1'b0, 5'd0, 0, 32'd0, 0);
    push_bus(32'h0000_7F18, 1'b0, 4'b0000, 32'd0, 1'b1, 32'h0000_0042);
    do_op("lw_tc1cnt", 1'b1, 1'b0, MT_W, 32'h0000_7F18, 32'd0, 1'b0, 5'd0, 0, 32'h0000_0042, 0);

    exc_q.push_back(EXC_ADEL);
    do_op("lw_mis", 1'b1, 1'b0, MT_W, 32'h0000_0002, 32'd0, 1'b0, 5'd0, 0, 32'd0, 0);
    exc_q.push_back(EXC_ADES);
    do_op("sw_tccnt", 1'b0, 1'b1, MT_W, 32'h0000_7F08, 32'd0, 1'b0, 5'd0, 0, 32'd0, 0);
    exc_q.push_back(EXC_ADES);
    do_op("sb_tc", 1'b0, 1'b1, MT_BS, 32'h0000_7F04, 32'd0, 1'b0, 5'd0, 0, 32'd0, 0);
    exc_q.push_back(EXC_ADEL);
    do_op("lw_range", 1'b1, 1'b0, MT_W, 32'h0000_3000, 32'd0, 1'b0, 5'd0, 0, 32'd0, 0);
    exc_q.push_back(EXC_ADES);
    do_op("sw_igend", 1'b0, 1'b1, MT_W, 32'h0000_7F24, 32'd0, 1'b0, 5'd0, 0, 32'd0, 0);
    exc_q.push_back(EXC_ADEL);
    do_op("ld_ov", 1'b1, 1'b0, MT_W, 32'h0000_0001, 32'd0, 1'b1, 5'd0, 0, 32'd0, 0);
    exc_q.push_back(5'd10);
    do_op("carried", 1'b1, 1'b0, MT_W, 32'h0000_0002, 32'd0, 1'b0, 5'd10, 0, 32'd0, 0);

    flush_run(1'b0);
    flush_run(1'b1);
    repeat (2) @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("exc_q_drained", exc_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
